// File: rtl/bp_unicore_dma_mux.sv
// Merges the per-bank L2 DMA channels into one DRAM DMA channel.
// Packets are arbitrated round-robin, a granted write locks the write-data
// path to its bank for a whole burst, and an in-order FIFO of bank ids
// steers read fill beats back to the bank that issued each read.
// All paths are combinational pass-through; only control state is registered.
module bp_unicore_dma_mux #(
   parameter int banks_p       = 2,
   parameter int daddr_width_p = 32,
   parameter int fill_width_p  = 64,
   parameter int burst_len_p   = 8,
   parameter int rd_els_p      = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic [banks_p*(daddr_width_p+1)-1:0]   dma_pkt_i,
   input  logic [banks_p-1:0]                     dma_pkt_v_i,
   output logic [banks_p-1:0]                     dma_pkt_ready_and_o,
   input  logic [banks_p*fill_width_p-1:0]        dma_data_i,
   input  logic [banks_p-1:0]                     dma_data_v_i,
   output logic [banks_p-1:0]                     dma_data_ready_and_o,
   output logic [banks_p*fill_width_p-1:0]        dma_data_o,
   output logic [banks_p-1:0]                     dma_data_v_o,
   input  logic [banks_p-1:0]                     dma_data_ready_and_i,
   output logic [daddr_width_p:0]                 mem_pkt_o,
   output logic                                   mem_pkt_v_o,
   input  logic                                   mem_pkt_ready_and_i,
   output logic [fill_width_p-1:0]                mem_data_o,
   output logic                                   mem_data_v_o,
   input  logic                                   mem_data_ready_and_i,
   input  logic [fill_width_p-1:0]                mem_data_i,
   input  logic                                   mem_data_v_i,
   output logic                                   mem_data_ready_and_o
);

   localparam int pkt_w_lp = daddr_width_p + 1;
   localparam int cnt_w_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
   localparam int id_w_lp  = (banks_p > 1) ? $clog2(banks_p) : 1;
   localparam int ptr_w_lp = (rd_els_p > 1) ? $clog2(rd_els_p) : 1;
   localparam int occ_w_lp = $clog2(rd_els_p + 1);

   localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(burst_len_p - 1);
   localparam logic [ptr_w_lp-1:0] last_ptr_lp  = ptr_w_lp'(rd_els_p - 1);
   localparam logic [id_w_lp-1:0]  last_id_lp   = id_w_lp'(banks_p - 1);
   localparam logic [occ_w_lp-1:0] full_occ_lp  = occ_w_lp'(rd_els_p);

   typedef enum logic {IDLE, WR_BURST} state_e;

   state_e                state_q, state_d;
   logic [id_w_lp-1:0]    rr_q, rr_d;
   logic [id_w_lp-1:0]    owner_q, owner_d;
   logic [cnt_w_lp-1:0]   wcnt_q, wcnt_d;
   logic [cnt_w_lp-1:0]   rcnt_q, rcnt_d;
   logic [ptr_w_lp-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ptr_w_lp-1:0]   rd_ptr_q, rd_ptr_d;
   logic [occ_w_lp-1:0]   occ_q, occ_d;
   logic [id_w_lp-1:0]    fifo_mem_q [rd_els_p];

   logic [pkt_w_lp-1:0]     pkt_arr   [banks_p];
   logic [fill_width_p-1:0] wdata_arr [banks_p];
   logic [banks_p-1:0]      eligible;
   logic                    fifo_full, fifo_empty;
   logic [id_w_lp-1:0]      head_id;
   logic                    grant_v, grant_is_wr;
   logic [id_w_lp-1:0]      grant_id;
   logic [id_w_lp:0]        arb_sum;
   logic                    pkt_fire, wr_fire, rd_fire, push, pop;

   assign fifo_full  = (occ_q == full_occ_lp);
   assign fifo_empty = (occ_q == '0);
   assign head_id    = fifo_mem_q[rd_ptr_q];

   // A read may only be granted if its bank id can be queued for the return.
   for (genvar gi = 0; gi < banks_p; gi++) begin : g_bank
      assign pkt_arr[gi]   = dma_pkt_i[gi*pkt_w_lp +: pkt_w_lp];
      assign wdata_arr[gi] = dma_data_i[gi*fill_width_p +: fill_width_p];
      assign eligible[gi]  = dma_pkt_v_i[gi] & (pkt_arr[gi][daddr_width_p] | ~fifo_full);
   end

   // Round-robin arbiter: first eligible bank at or after the rr pointer.
   always_comb begin
      grant_v  = 1'b0;
      grant_id = '0;
      arb_sum  = '0;
      for (int k = 0; k < banks_p; k++) begin
         arb_sum = {1'b0, rr_q} + (id_w_lp+1)'(k);
         if (arb_sum >= (id_w_lp+1)'(banks_p)) arb_sum = arb_sum - (id_w_lp+1)'(banks_p);
         if (!grant_v && eligible[arb_sum[id_w_lp-1:0]]) begin
            grant_v  = 1'b1;
            grant_id = arb_sum[id_w_lp-1:0];
         end
      end
   end

   assign grant_is_wr = pkt_arr[grant_id][daddr_width_p];
   assign pkt_fire    = (state_q == IDLE) & grant_v & mem_pkt_ready_and_i;
   assign wr_fire     = (state_q == WR_BURST) & dma_data_v_i[owner_q] & mem_data_ready_and_i;
   assign rd_fire     = mem_data_v_i & mem_data_ready_and_o;
   assign push        = pkt_fire & ~grant_is_wr;
   assign pop         = rd_fire & (rcnt_q == last_beat_lp);

   // FSM state register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // FSM next state: a write packet locks the data path until its last beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (pkt_fire && grant_is_wr) state_d = WR_BURST;
         WR_BURST: if (wr_fire && (wcnt_q == last_beat_lp)) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // FSM outputs: packet offer in IDLE, owner's write data in WR_BURST; silent in reset.
   always_comb begin
      mem_pkt_o            = pkt_arr[grant_id];
      mem_pkt_v_o          = 1'b0;
      dma_pkt_ready_and_o  = '0;
      mem_data_o           = wdata_arr[owner_q];
      mem_data_v_o         = 1'b0;
      dma_data_ready_and_o = '0;
      if (reset_n_i) begin
         case (state_q)
            IDLE: begin
               mem_pkt_v_o = grant_v;
               if (grant_v) dma_pkt_ready_and_o[grant_id] = mem_pkt_ready_and_i;
            end
            WR_BURST: begin
               mem_data_v_o                  = dma_data_v_i[owner_q];
               dma_data_ready_and_o[owner_q] = mem_data_ready_and_i;
            end
            default: ;
         endcase
      end
   end

   // Read return: fill data is broadcast, valid/ready follow the FIFO head bank.
   always_comb begin
      dma_data_o           = {banks_p{mem_data_i}};
      dma_data_v_o         = '0;
      mem_data_ready_and_o = 1'b0;
      if (reset_n_i && !fifo_empty) begin
         dma_data_v_o[head_id] = mem_data_v_i;
         mem_data_ready_and_o  = dma_data_ready_and_i[head_id];
      end
   end

   // Next values for arbitration pointer, burst counters and FIFO bookkeeping.
   always_comb begin
      rr_d     = rr_q;
      owner_d  = owner_q;
      wcnt_d   = wcnt_q;
      rcnt_d   = rcnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (pkt_fire) begin
         rr_d = (grant_id == last_id_lp) ? '0 : grant_id + 1'b1;
         if (grant_is_wr) begin
            owner_d = grant_id;
            wcnt_d  = '0;
         end
      end
      if (wr_fire) wcnt_d = (wcnt_q == last_beat_lp) ? '0 : wcnt_q + 1'b1;
      if (rd_fire) rcnt_d = (rcnt_q == last_beat_lp) ? '0 : rcnt_q + 1'b1;
      if (push) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   // Control registers; reset drops every in-flight burst and queued read.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_q     <= '0;
         owner_q  <= '0;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         rr_q     <= rr_d;
         owner_q  <= owner_d;
         wcnt_q   <= wcnt_d;
         rcnt_q   <= rcnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Bank-id FIFO storage; contents are meaningless while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem_q[wr_ptr_q] <= grant_id;
   end

endmodule
